// File: rtl/traffic_phase_scheduler_pkg.sv
// traffic_pkg: phase encoding, lamp codes and the phase-to-lamp decode shared by the scheduler
package traffic_pkg;
  typedef enum logic [3:0] {G1 = 4'd0, Y1, AR1, G2, Y2, AR2, PED, EMG} phase_e;
  localparam logic [2:0] LED_R = 3'b100;
  localparam logic [2:0] LED_Y = 3'b010;
  localparam logic [2:0] LED_G = 3'b001;
  function automatic logic [5:0] leds_of(phase_e p);
    return p == G1 ? {LED_G, LED_R} :
           p == Y1 ? {LED_Y, LED_R} :
           p == G2 ? {LED_R, LED_G} :
           p == Y2 ? {LED_R, LED_Y} : {LED_R, LED_R};
  endfunction
endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if: request inputs and light/phase outputs of the scheduler
interface traffic_phase_scheduler_if #(parameter int CNT_W = 8);
  logic             enable;
  logic             ped_req;
  logic             emg_req;
  logic [2:0]       led_traffic1;
  logic [2:0]       led_traffic2;
  logic             ped_walk;
  logic [3:0]       phase;
  logic [CNT_W-1:0] timer;
  modport master (output enable, ped_req, emg_req,
                  input led_traffic1, led_traffic2, ped_walk, phase, timer);
  modport slave (input enable, ped_req, emg_req,
                 output led_traffic1, led_traffic2, ped_walk, phase, timer);
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// phase_timer: loadable down-counter that saturates at zero
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] value_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? value_i : (dec_i && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= RST_VAL;
    else if (en_i) cnt_q <= cnt_d;
  assign cnt_o  = cnt_q;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: two-road light sequencer with latched ped walk and emergency preemption
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int TIME_G     = 10,
  parameter int TIME_G_MIN = 4,
  parameter int TIME_Y     = 5,
  parameter int TIME_AR    = 2,
  parameter int TIME_PED   = 8
) (
  input logic clk,
  input logic rst,
  traffic_phase_scheduler_if.slave bus
);
  localparam logic [CNT_W-1:0] CUT_MAX = CNT_W'(TIME_G - 1 - TIME_G_MIN);
  phase_e           state_q, state_d, ar_next;
  logic             ped_q, ped_d, side_q, side_d, walk_q, zero, load, cut;
  logic [2:0]       l1_q, l2_q;
  logic [CNT_W-1:0] cnt, load_val;
  always_comb begin
    cut     = (ped_q | bus.emg_req) && cnt <= CUT_MAX;
    ar_next = bus.emg_req ? EMG : ped_q ? PED : state_q == AR1 ? G2 : G1;
    state_d = state_q;
    case (state_q)
      G1:      if (cut || zero) state_d = Y1;
      Y1:      if (zero) state_d = AR1;
      AR1:     if (zero) state_d = ar_next;
      G2:      if (cut || zero) state_d = Y2;
      Y2:      if (zero) state_d = AR2;
      AR2:     if (zero) state_d = ar_next;
      PED:     if (zero) state_d = bus.emg_req ? EMG : side_q ? G2 : G1;
      EMG:     if (!bus.emg_req) state_d = AR2;
      default: state_d = AR2;
    endcase
    if (!bus.enable) state_d = state_q;
    load     = state_d != state_q;
    load_val = (state_d == G1 || state_d == G2) ? CNT_W'(TIME_G - 1) :
               (state_d == Y1 || state_d == Y2) ? CNT_W'(TIME_Y - 1) :
               state_d == PED ? CNT_W'(TIME_PED - 1) :
               state_d == EMG ? '0 : CNT_W'(TIME_AR - 1);
    ped_d    = bus.ped_req | (ped_q & ~(load && state_d == PED));
    // remember which green a ped phase taken out of all-red must hand back to
    side_d   = (bus.enable && (state_q == AR1 || state_q == AR2)) ? state_q == AR1 : side_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= AR2;
      ped_q   <= 1'b0;
      side_q  <= 1'b0;
      l1_q    <= LED_R;
      l2_q    <= LED_R;
      walk_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ped_q        <= ped_d;
      side_q       <= side_d;
      {l1_q, l2_q} <= leds_of(state_d);
      walk_q       <= state_d == PED;
    end
  phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(TIME_AR - 1))) u_timer (
    .clk(clk), .rst(rst), .load_i(load), .en_i(bus.enable), .dec_i(state_q != EMG),
    .value_i(load_val), .cnt_o(cnt), .zero_o(zero)
  );
  assign bus.led_traffic1 = l1_q;
  assign bus.led_traffic2 = l2_q;
  assign bus.ped_walk     = walk_q;
  assign bus.phase        = state_q;
  assign bus.timer        = cnt;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed phase/timer/light checks with hand-computed expectations
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  traffic_phase_scheduler_if #(.CNT_W(8)) bus();
  traffic_phase_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [6:0] exp_out(phase_e p);
    case (p)
      G1:      return 7'b001_100_0;
      Y1:      return 7'b010_100_0;
      G2:      return 7'b100_001_0;
      Y2:      return 7'b100_010_0;
      PED:     return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic exp_st(input string tag, input phase_e p, input int t);
    check({tag, " phase"}, 32'(bus.phase), 32'(p));
    check({tag, " timer"}, 32'(bus.timer), 32'(t));
    check({tag, " lights"}, 32'({bus.led_traffic1, bus.led_traffic2, bus.ped_walk}), 32'(exp_out(p)));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.enable = 1'b1; bus.ped_req = 1'b0; bus.emg_req = 1'b0;
    tick(2);
    rst = 1'b0;
    exp_st("reset", AR2, 1);
    // plain cycle
    tick(1);  exp_st("t1 ar2 end", AR2, 0);
    tick(1);  exp_st("t1 g1", G1, 9);
    tick(10); exp_st("t1 y1", Y1, 4);
    tick(5);  exp_st("t1 ar1", AR1, 1);
    tick(2);  exp_st("t1 g2", G2, 9);
    tick(10); exp_st("t1 y2", Y2, 4);
    tick(5);  exp_st("t1 ar2", AR2, 1);
    // pedestrian cuts G1 at elapsed 4
    tick(2);  exp_st("t2 g1", G1, 9);
    tick(1);  bus.ped_req = 1'b1;
    tick(1);  bus.ped_req = 1'b0; exp_st("t2 g1 e2", G1, 7);
    tick(2);  exp_st("t2 g1 e4", G1, 5);
    tick(1);  exp_st("t2 y1", Y1, 4);
    tick(5);  exp_st("t2 ar1", AR1, 1);
    tick(2);  exp_st("t2 ped", PED, 7);
    tick(8);  exp_st("t2 g2", G2, 9);
    tick(9);  exp_st("t2 g2 full", G2, 0);
    tick(1);  exp_st("t2 y2", Y2, 4);
    // emergency during yellow
    tick(2);  exp_st("t3 y2 mid", Y2, 2);
    bus.emg_req = 1'b1;
    tick(2);  exp_st("t3 y2 end", Y2, 0);
    tick(1);  exp_st("t3 ar2", AR2, 1);
    tick(2);  exp_st("t3 emg", EMG, 0);
    tick(15); exp_st("t3 emg hold", EMG, 0);
    bus.emg_req = 1'b0;
    tick(1);  exp_st("t3 ar2 clr", AR2, 1);
    tick(2);  exp_st("t3 g1", G1, 9);
    // simultaneous ped + emergency in G2
    tick(9);  exp_st("t4 g1 end", G1, 0);
    tick(1);  exp_st("t4 y1", Y1, 4);
    tick(5);  exp_st("t4 ar1", AR1, 1);
    tick(2);  exp_st("t4 g2", G2, 9);
    tick(6);  exp_st("t4 g2 e6", G2, 3);
    bus.ped_req = 1'b1; bus.emg_req = 1'b1;
    tick(1);  bus.ped_req = 1'b0; exp_st("t4 y2", Y2, 4);
    tick(5);  exp_st("t4 ar2", AR2, 1);
    tick(2);  exp_st("t4 emg", EMG, 0);
    tick(3);  exp_st("t4 emg hold", EMG, 0);
    bus.emg_req = 1'b0;
    tick(1);  exp_st("t4 ar2 clr", AR2, 1);
    tick(2);  exp_st("t4 ped", PED, 7);
    tick(8);  exp_st("t4 g1", G1, 9);
    // freeze with a ped request latched meanwhile
    tick(6);  exp_st("t5 g1 t3", G1, 3);
    bus.enable = 1'b0;
    tick(1);  bus.ped_req = 1'b1;
    tick(1);  bus.ped_req = 1'b0; exp_st("t5 frozen", G1, 3);
    tick(5);  exp_st("t5 frozen end", G1, 3);
    bus.enable = 1'b1;
    tick(1);  exp_st("t5 cut", Y1, 4);
    tick(5);  exp_st("t5 ar1", AR1, 1);
    tick(2);  exp_st("t5 ped", PED, 7);
    // async reset mid-PED drops an owed ped
    tick(2);  bus.ped_req = 1'b1;
    tick(1);  bus.ped_req = 1'b0; exp_st("t6 ped", PED, 4);
    #2 rst = 1'b1;
    #1 exp_st("t6 async", AR2, 1);
    #2 rst = 1'b0;
    tick(2);  exp_st("t6 g1", G1, 9);
    tick(5);  exp_st("t6 no ped", G1, 4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
